// File: rtl/tama_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tama_pkg : mood encodings and default thresholds for the need monitor    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package tama_pkg;

  localparam logic [1:0] c_MOOD_OK       = 2'd0;
  localparam logic [1:0] c_MOOD_NEEDY    = 2'd1;
  localparam logic [1:0] c_MOOD_CRITICAL = 2'd2;
  localparam logic [1:0] c_MOOD_DEAD     = 2'd3;

  localparam int c_DEF_NUM_NEEDS  = 6;
  localparam int c_DEF_LVL_W      = 5;
  localparam int c_DEF_WARN_TH    = 12;
  localparam int c_DEF_CLR_TH     = 8;
  localparam int c_DEF_CRIT_TH    = 14;
  localparam int c_DEF_DEATH_HOLD = 4;

endpackage
`default_nettype wire

// File: rtl/need_channel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | need_channel : per-channel hysteresis plus critical / full-scale compare |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module need_channel #(
  parameter int LVL_W   = 5,
  parameter int WARN_TH = 12,
  parameter int CLR_TH  = 8,
  parameter int CRIT_TH = 14
) (
  input  logic [LVL_W-1:0] i_level,
  input  logic             i_mask,
  input  logic             i_alert_q,
  output logic             o_alert_d,
  output logic             o_crit,
  output logic             o_full
);

  localparam logic [LVL_W-1:0] c_WARN = LVL_W'(WARN_TH);
  localparam logic [LVL_W-1:0] c_CLR  = LVL_W'(CLR_TH);
  localparam logic [LVL_W-1:0] c_CRIT = LVL_W'(CRIT_TH);
  localparam logic [LVL_W-1:0] c_FULL = '1;

  // Between the two thresholds the previous flag is kept.
  always_comb begin
    o_alert_d = i_alert_q;
    if (i_mask) begin
      o_alert_d = 1'b0;
    end else if (i_level >= c_WARN) begin
      o_alert_d = 1'b1;
    end else if (i_level <= c_CLR) begin
      o_alert_d = 1'b0;
    end
  end

  assign o_crit = !i_mask && (i_level >= c_CRIT);
  assign o_full = !i_mask && (i_level == c_FULL);

endmodule
`default_nettype wire

// File: rtl/need_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | need_monitor : hysteretic need alerts, priority pick, mood FSM, death    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module need_monitor #(
  parameter int NUM_NEEDS  = tama_pkg::c_DEF_NUM_NEEDS,
  parameter int LVL_W      = tama_pkg::c_DEF_LVL_W,
  parameter int WARN_TH    = tama_pkg::c_DEF_WARN_TH,
  parameter int CLR_TH     = tama_pkg::c_DEF_CLR_TH,
  parameter int CRIT_TH    = tama_pkg::c_DEF_CRIT_TH,
  parameter int DEATH_HOLD = tama_pkg::c_DEF_DEATH_HOLD
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tick,
  input  logic [NUM_NEEDS*LVL_W-1:0]     levels,
  input  logic [NUM_NEEDS-1:0]           mask,
  output logic [NUM_NEEDS-1:0]           alert,
  output logic [$clog2(NUM_NEEDS)-1:0]   top_need,
  output logic                           top_valid,
  output logic [1:0]                     mood,
  output logic                           new_alert,
  output logic                           dead
);
  import tama_pkg::*;

  localparam int c_IDX_W = $clog2(NUM_NEEDS);
  localparam int c_CNT_W = $clog2(DEATH_HOLD + 1);
  localparam logic [c_CNT_W-1:0] c_HOLD = c_CNT_W'(DEATH_HOLD);

  if (!((CLR_TH < WARN_TH) && (WARN_TH <= CRIT_TH) &&
        (CRIT_TH <= (1 << LVL_W) - 1) && (DEATH_HOLD >= 1) &&
        (NUM_NEEDS >= 2))) begin : g_bad_params
    $error("need_monitor: illegal parameter combination");
  end

  logic [NUM_NEEDS-1:0] r_alert_q;
  logic [c_IDX_W-1:0]   r_top_q;
  logic                 r_valid_q;
  logic [1:0]           r_mood_q;
  logic                 r_new_q;
  logic [c_CNT_W-1:0]   r_cnt_q;

  logic [NUM_NEEDS-1:0] w_alert_d;
  logic [NUM_NEEDS-1:0] w_crit;
  logic [NUM_NEEDS-1:0] w_full;
  logic [c_IDX_W-1:0]   w_top_d;
  logic [1:0]           w_mood_d;
  logic [c_CNT_W-1:0]   w_cnt_d;
  logic                 w_die;
  logic                 w_dead;

  for (genvar gi = 0; gi < NUM_NEEDS; gi++) begin : g_ch
    need_channel #(
      .LVL_W   (LVL_W),
      .WARN_TH (WARN_TH),
      .CLR_TH  (CLR_TH),
      .CRIT_TH (CRIT_TH)
    ) u_ch (
      .i_level   (levels[gi*LVL_W +: LVL_W]),
      .i_mask    (mask[gi]),
      .i_alert_q (r_alert_q[gi]),
      .o_alert_d (w_alert_d[gi]),
      .o_crit    (w_crit[gi]),
      .o_full    (w_full[gi])
    );
  end

  assign w_dead = (r_mood_q == c_MOOD_DEAD);

  always_comb begin
    w_cnt_d = '0;
    if (|w_full) begin
      w_cnt_d = (r_cnt_q == c_HOLD) ? r_cnt_q : r_cnt_q + 1'b1;
    end
    w_die = (w_cnt_d == c_HOLD);
  end

  // Scan high to low so the lowest set index is the one left standing.
  always_comb begin
    w_top_d = '0;
    for (int i = NUM_NEEDS - 1; i >= 0; i--) begin
      if (w_alert_d[i]) begin
        w_top_d = c_IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_mood_d = c_MOOD_OK;
    if (|w_crit) begin
      w_mood_d = c_MOOD_CRITICAL;
    end else if (|w_alert_d) begin
      w_mood_d = c_MOOD_NEEDY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alert_q <= '0;
      r_top_q   <= '0;
      r_valid_q <= 1'b0;
      r_mood_q  <= c_MOOD_OK;
      r_new_q   <= 1'b0;
      r_cnt_q   <= '0;
    end else begin
      r_new_q <= 1'b0;
      if (tick && !w_dead) begin
        r_cnt_q <= w_cnt_d;
        if (w_die) begin
          r_alert_q <= '1;
          r_top_q   <= '0;
          r_valid_q <= 1'b1;
          r_mood_q  <= c_MOOD_DEAD;
        end else begin
          r_alert_q <= w_alert_d;
          r_top_q   <= w_top_d;
          r_valid_q <= |w_alert_d;
          r_mood_q  <= w_mood_d;
          r_new_q   <= |(w_alert_d & ~r_alert_q);
        end
      end
    end
  end

  assign alert     = r_alert_q;
  assign top_need  = r_top_q;
  assign top_valid = r_valid_q;
  assign mood      = r_mood_q;
  assign new_alert = r_new_q;
  assign dead      = w_dead;

endmodule
`default_nettype wire

// File: doc/need_monitor.md
NEED_MONITOR -- requirements
Module: need_monitor

Interface
REQ-001 Parameter NUM_NEEDS, default 6, number of need channels; channel 0 = hunger, 1 = happiness, 2 = health, 3 = hygiene, 4 = energy, 5 = social.
REQ-002 Parameter LVL_W, default 5, width of each need level.
REQ-003 Parameter WARN_TH, default 12, level at or above which a channel alert sets.
REQ-004 Parameter CLR_TH, default 8, level at or below which a channel alert clears.
REQ-005 Parameter CRIT_TH, default 14, level at or above which a channel is critical.
REQ-006 Parameter DEATH_HOLD, default 4, consecutive ticks at full scale needed to declare death.
REQ-007 clk  in  1  sole clock; all logic on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 tick  in  1  sample strobe; levels are evaluated only on cycles where tick=1.
REQ-010 levels  in  NUM_NEEDS*LVL_W  packed levels; channel i occupies bits [i*LVL_W +: LVL_W].
REQ-011 mask  in  NUM_NEEDS  1 = channel ignored.
REQ-012 alert  out  NUM_NEEDS  per-channel hysteretic need flag.
REQ-013 top_need  out  clog2(NUM_NEEDS)  index of highest-priority active alert.
REQ-014 top_valid  out  1  at least one alert bit set.
REQ-015 mood  out  2  0=OK, 1=NEEDY, 2=CRITICAL, 3=DEAD.
REQ-016 new_alert  out  1  one-cycle pulse when any alert bit rises.
REQ-017 dead  out  1  equals (mood==DEAD).

Function
REQ-018 All outputs SHALL be registered and SHALL update exactly one clk after a tick=1 cycle; when tick=0 they SHALL hold, except that new_alert SHALL return to 0.
REQ-019 Per unmasked channel on tick: alert SHALL set if level>=WARN_TH, clear if level<=CLR_TH, and otherwise hold.
REQ-020 A masked channel SHALL force its alert to 0 on the next tick and SHALL be excluded from the critical and death checks.
REQ-021 top_need SHALL be the lowest set alert index; when top_valid=0, top_need SHALL be 0.
REQ-022 new_alert SHALL be 1 for exactly one cycle when (alert_next & ~alert_prev) != 0 on a tick.
REQ-023 Death counter, width clog2(DEATH_HOLD+1): on tick, it SHALL increment, saturating at DEATH_HOLD, if any unmasked level equals 2^LVL_W-1; otherwise it SHALL clear to 0.
REQ-024 FSM transitions SHALL be evaluated on tick only:
  - any state to DEAD when the counter reaches DEATH_HOLD;
  - otherwise CRITICAL if any unmasked level>=CRIT_TH;
  - otherwise NEEDY if any alert_next bit is set;
  - otherwise OK.
REQ-025 DEAD SHALL be absorbing until reset: tick is ignored, alert SHALL be all ones, top_valid=1, top_need=0, and new_alert SHALL not pulse.
REQ-026 If the death condition and a new alert occur on the same tick, DEAD SHALL win and new_alert SHALL stay 0.
REQ-027 Elaboration SHALL fail unless CLR_TH < WARN_TH <= CRIT_TH <= 2^LVL_W-1, DEATH_HOLD >= 1, and NUM_NEEDS >= 2.

Reset
REQ-028 reset=1 SHALL, on the next clk edge, set alert=0, top_need=0, top_valid=0, mood=OK, new_alert=0, dead=0, and death counter=0.
REQ-029 reset SHALL take priority over tick, including mid-countdown and in DEAD.

Structure
REQ-030 Mood encodings and default threshold constants SHALL live in shared package tama_pkg.
REQ-031 Per-channel hysteresis and critical comparison SHALL be sub-module need_channel, instantiated NUM_NEEDS times via generate; the priority encoder, death counter and FSM SHALL remain in need_monitor.

Verification
REQ-032 Hysteresis: ch2 levels 11, 12, 10, 8 on four ticks -> alert[2] = 0, 1, 1, 0; new_alert pulses only after the second tick.
REQ-033 Priority: ch4=13 and ch1=13 on one tick -> top_need=1, mood=NEEDY; then ch1=0 -> top_need=4 after the next tick.
REQ-034 Death: ch0=31 for 3 ticks then 20 -> counter returns to 0 with no DEAD; ch0=31 for 4 ticks -> mood=3, alert=6'b111111, dead=1; subsequent levels=0 leave it unchanged.
REQ-035 Mask: ch5=31 with mask[5]=1 for 10 ticks -> alert[5]=0, mood=OK, dead=0.
REQ-036 Reset mid-operation: assert reset during DEAD and again after 2 of 4 death ticks -> all outputs are 0 one clk later; 4 further ticks of ch0=31 are then required before DEAD.
REQ-037 No tick: change levels with tick=0 for 20 cycles -> outputs unchanged.
